// File: rtl/gftt_seq.sv
// Frame sequencer: queues rect_done events, starts the pipeline one frame at a time, rotates buf_idx, watches for timeout.
// Latency: push to start 2 cycles, gftt_done to next start 2 cycles; no backpressure, a push into a full queue is dropped and counted.
module gftt_seq #(
    parameter int NBUF       = 2,
    parameter int PEND_DEPTH = 4,
    parameter int FCNT_W     = 4,
    parameter int TOUT_W     = 24
) (
    input  logic                    rst_n,
    input  logic                    clk,
    input  logic                    ibus_cs,
    input  logic                    ibus_wr,
    input  logic [5:0]              ibus_addr_7_2,
    input  logic [31:0]             ibus_wrdata,
    output logic [31:0]             ibus_rddata,
    input  logic                    rect_done,
    input  logic [FCNT_W-1:0]       rect_fcnt,
    input  logic                    gftt_done,
    output logic                    enb,
    output logic                    start,
    output logic                    abort,
    output logic                    busy,
    output logic [FCNT_W-1:0]       gftt_fcnt,
    output logic [$clog2(NBUF)-1:0] buf_idx
);
    localparam int BW = $clog2(NBUF);
    localparam int AW = $clog2(PEND_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [TOUT_W-1:0]  tout_lim;
    logic [TOUT_W-1:0]  tout_cnt;
    logic [15:0]        done_cnt;
    logic [15:0]        drop_cnt;
    logic               ovf;
    logic               tout;

    logic [FCNT_W-1:0]  fifo_mem [PEND_DEPTH];
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [CW-1:0]      pend_cnt;
    logic [4:0]         pend5;

    logic wr_ctrl, wr_tlim, sw_start, clr_stat, dis;
    logic push_req, push_ok, pop, drop, fifo_empty, fifo_full;
    logic run_done, tout_hit;
    logic unused_wrdata;

    assign wr_ctrl  = ibus_cs & ibus_wr & (ibus_addr_7_2 == 6'd0);
    assign wr_tlim  = ibus_cs & ibus_wr & (ibus_addr_7_2 == 6'd3);
    assign sw_start = wr_ctrl & ibus_wrdata[1];
    assign clr_stat = wr_ctrl & ibus_wrdata[2];
    assign dis      = wr_ctrl & ~ibus_wrdata[0];
    assign unused_wrdata = ^ibus_wrdata;

    assign fifo_empty = (pend_cnt == '0);
    assign fifo_full  = (pend_cnt == CW'(PEND_DEPTH));
    assign push_req   = (rect_done | sw_start) & enb;
    assign pop        = (state_q == S_IDLE) & enb & ~fifo_empty & ~dis;
    // A pop on the same edge frees the slot, so a push on full is still accepted.
    assign push_ok    = push_req & (~fifo_full | pop) & ~dis;
    assign drop       = push_req & fifo_full & ~pop & ~dis;

    assign run_done = (state_q == S_RUN) & gftt_done;
    assign tout_hit = (state_q == S_RUN) & (tout_lim != '0) &
                      (tout_cnt == tout_lim - TOUT_W'(1)) & ~gftt_done;

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= rect_fcnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            pend_cnt <= '0;
        end else if (dis) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            pend_cnt <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)
                pend_cnt <= pend_cnt + CW'(1);
            else if (pop && !push_ok)
                pend_cnt <= pend_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pop) state_d = S_START;
            S_START: state_d = S_RUN;
            S_RUN:   if (run_done || tout_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (dis)
            state_d = S_IDLE;
    end

    always_comb begin
        start = (state_q == S_START);
        busy  = (state_q == S_START) || (state_q == S_RUN);
        abort = tout_hit | (dis & busy);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enb       <= 1'b0;
            tout_lim  <= '0;
            gftt_fcnt <= '0;
            buf_idx   <= '0;
            tout_cnt  <= '0;
        end else begin
            if (wr_ctrl)
                enb <= ibus_wrdata[0];
            if (wr_tlim)
                tout_lim <= ibus_wrdata[TOUT_W-1:0];
            if (pop) begin
                gftt_fcnt <= fifo_mem[rd_ptr];
                buf_idx   <= (buf_idx == BW'(NBUF - 1)) ? '0 : buf_idx + BW'(1);
            end
            tout_cnt <= (state_q == S_RUN) ? tout_cnt + TOUT_W'(1) : '0;
        end
    end

    // Statistics: a clear in the same cycle as an event wins over the event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
            drop_cnt <= '0;
            ovf      <= 1'b0;
            tout     <= 1'b0;
        end else if (clr_stat) begin
            done_cnt <= '0;
            drop_cnt <= '0;
            ovf      <= 1'b0;
            tout     <= 1'b0;
        end else begin
            if (run_done && done_cnt != 16'hFFFF)
                done_cnt <= done_cnt + 16'd1;
            if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            if (drop)
                ovf <= 1'b1;
            if (tout_hit)
                tout <= 1'b1;
        end
    end

    assign pend5 = 5'(pend_cnt);

    always_comb begin
        ibus_rddata = '0;
        if (ibus_cs) begin
            case (ibus_addr_7_2)
                6'd0:    ibus_rddata = {31'b0, enb};
                6'd1:    ibus_rddata = {24'b0, ovf, tout, busy, pend5};
                6'd2:    ibus_rddata = {drop_cnt, done_cnt};
                6'd3:    ibus_rddata[TOUT_W-1:0] = tout_lim;
                default: ibus_rddata = '0;
            endcase
        end
    end

endmodule
